// File: rtl/sockit_spi_pkg.sv
// rtl/sockit_spi_pkg.sv - shared SPI master encodings, command layout and FSM states
package sockit_spi_pkg;

  // I/O mode encodings
  localparam logic [1:0] IOM_SNG = 2'd0;
  localparam logic [1:0] IOM_3WR = 2'd1;
  localparam logic [1:0] IOM_DUA = 2'd2;
  localparam logic [1:0] IOM_QUA = 2'd3;

  // chunk word layout: {lst, ien, oen, iom[1:0], cnt[4:0], dat[31:0]}
  localparam int CMD_W   = 10;
  localparam int DAT_W   = 32;
  localparam int CMD_CNT = 32;
  localparam int CMD_IOM = 37;
  localparam int CMD_OEN = 39;
  localparam int CMD_IEN = 40;
  localparam int CMD_LST = 41;

  // transfer splitter states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WDAT = 2'd1,
    ST_EMIT = 2'd2
  } xfr_state_t;

  // reverse byte order so the lowest-address byte is sent first
  function automatic logic [31:0] bswap32(input logic [31:0] d);
    bswap32 = {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

endpackage

// File: rtl/sockit_spi_xfr.sv
// rtl/sockit_spi_xfr.sv - splits a bit-length transfer into <=32-bit command+data chunks (option: SOCKIT_SPI_XFR_BSWAP_EN)
module sockit_spi_xfr
  import sockit_spi_pkg::*;
#(
  parameter int LW = 16,
  parameter int DW = 42
)(
  input  logic          cdi_clk,
  input  logic          cdi_rst,
  input  logic [LW-1:0] xfr_len,
  input  logic [1:0]    xfr_iom,
  input  logic          xfr_oen,
  input  logic          xfr_ien,
  input  logic          xfr_req,
  output logic          xfr_grt,
  input  logic [31:0]   bus_dat,
  input  logic          bus_req,
  output logic          bus_grt,
  output logic [DW-1:0] cdi_dat,
  output logic          cdi_req,
  input  logic          cdi_grt
);

  localparam logic [LW-1:0] CHUNK_MAX = LW'(32);

  xfr_state_t    state_q, state_nxt;
  logic [LW-1:0] rem_q, rem_nxt;
  logic [1:0]    iom_q, iom_nxt;
  logic          oen_q, oen_nxt;
  logic          ien_q, ien_nxt;
  logic          xfr_grt_nxt, bus_grt_nxt, cdi_req_nxt;
  logic [DW-1:0] cdi_dat_nxt;
  logic [31:0]   wdat;
  logic          emit_lst;
  logic [LW-1:0] emit_bits;

  // byte order of the write data as it will appear in the chunk
`ifdef SOCKIT_SPI_XFR_BSWAP_EN
  assign wdat = bswap32(bus_dat);
`else
  assign wdat = bus_dat;
`endif

  // size of the chunk currently offered from the remaining length
  assign emit_lst  = (rem_q <= CHUNK_MAX);
  assign emit_bits = emit_lst ? rem_q : CHUNK_MAX;

  // assemble one chunk word for a nonzero remaining length r
  function automatic logic [DW-1:0] chunk_word(
    input logic [LW-1:0] r,
    input logic          ien,
    input logic          oen,
    input logic [1:0]    iom,
    input logic [31:0]   d
  );
    logic [LW-1:0] rm1;
    logic          last;
    logic [DW-1:0] w;
    rm1  = r - LW'(1);
    last = (r <= CHUNK_MAX);
    w    = '0;
    w[CMD_LST]         = last;
    w[CMD_IEN]         = ien;
    w[CMD_OEN]         = oen;
    w[CMD_IOM +: 2]    = iom;
    w[CMD_CNT +: 5]    = last ? rm1[4:0] : 5'd31;
    w[0 +: DAT_W]      = d;
    return w;
  endfunction

  // state and registered outputs
  always_ff @(posedge cdi_clk or posedge cdi_rst) begin
    if (cdi_rst) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      iom_q   <= IOM_SNG;
      oen_q   <= 1'b0;
      ien_q   <= 1'b0;
      xfr_grt <= 1'b1;
      bus_grt <= 1'b0;
      cdi_req <= 1'b0;
      cdi_dat <= '0;
    end else begin
      state_q <= state_nxt;
      rem_q   <= rem_nxt;
      iom_q   <= iom_nxt;
      oen_q   <= oen_nxt;
      ien_q   <= ien_nxt;
      xfr_grt <= xfr_grt_nxt;
      bus_grt <= bus_grt_nxt;
      cdi_req <= cdi_req_nxt;
      cdi_dat <= cdi_dat_nxt;
    end
  end

  // next state, remaining length and next output values
  always_comb begin
    state_nxt   = state_q;
    rem_nxt     = rem_q;
    iom_nxt     = iom_q;
    oen_nxt     = oen_q;
    ien_nxt     = ien_q;
    xfr_grt_nxt = xfr_grt;
    bus_grt_nxt = bus_grt;
    cdi_req_nxt = cdi_req;
    cdi_dat_nxt = cdi_dat;
    case (state_q)
      ST_IDLE: begin
        if (xfr_req && xfr_grt) begin
          iom_nxt = xfr_iom;
          oen_nxt = xfr_oen;
          ien_nxt = xfr_ien;
          rem_nxt = xfr_len;
          if (xfr_len != '0) begin
            xfr_grt_nxt = 1'b0;
            if (xfr_oen) begin
              state_nxt   = ST_WDAT;
              bus_grt_nxt = 1'b1;
            end else begin
              state_nxt   = ST_EMIT;
              cdi_req_nxt = 1'b1;
              cdi_dat_nxt = chunk_word(xfr_len, xfr_ien, 1'b0, xfr_iom, 32'h0);
            end
          end
        end
      end
      ST_WDAT: begin
        if (bus_req && bus_grt) begin
          state_nxt   = ST_EMIT;
          bus_grt_nxt = 1'b0;
          cdi_req_nxt = 1'b1;
          cdi_dat_nxt = chunk_word(rem_q, ien_q, oen_q, iom_q, wdat);
        end
      end
      ST_EMIT: begin
        if (cdi_req && cdi_grt) begin
          rem_nxt = rem_q - emit_bits;
          if (emit_lst) begin
            state_nxt   = ST_IDLE;
            cdi_req_nxt = 1'b0;
            xfr_grt_nxt = 1'b1;
          end else if (oen_q) begin
            state_nxt   = ST_WDAT;
            cdi_req_nxt = 1'b0;
            bus_grt_nxt = 1'b1;
          end else begin
            cdi_dat_nxt = chunk_word(rem_nxt, ien_q, 1'b0, iom_q, 32'h0);
          end
        end
      end
      default: begin
        state_nxt   = ST_IDLE;
        xfr_grt_nxt = 1'b1;
        bus_grt_nxt = 1'b0;
        cdi_req_nxt = 1'b0;
      end
    endcase
  end

endmodule
